// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch redirect unit
package fetch_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic [31:0] fallthru;
  } entry_t;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  function automatic logic [31:0] b_offset(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/pred_queue.sv
// rtl/pred_queue.sv - FIFO of in-flight predicted branches, flush clears everything
module pred_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rstN,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t push_data,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  // a full queue still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC generation with branch prediction queue and mispredict redirect
// Optional FETCH_STATS_EN adds saturating branch/mispredict counters.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic        predictBranch,
  input  logic        resolveValid,
  input  logic        resolveTaken,
  input  logic [31:0] resolveTarget,
  output logic [31:0] pc,
  output logic        fetchValid,
  output logic [31:0] currInstr,
  output logic [31:0] prevInstr,
  output logic        branchTaken,
  output logic        trainValid,
  output logic        mispredict,
  output logic        queueFull,
  output logic [15:0] branchCount,
  output logic [15:0] mispredictCount
);

  state_t      state_q, state_d;
  logic [31:0] pc_d;
  logic        started;
  logic        is_branch;
  logic        push;
  logic        pop;
  logic        mis;
  logic        block;
  logic        empty;
  logic [31:0] redirect_pc;
  entry_t      head;
  entry_t      push_data;

  assign currInstr   = instr;
  assign is_branch   = (instr[6:0] == OPCODE_BRANCH);
  assign pop         = resolveValid && !empty;
  assign mis         = pop && (resolveTaken != head.pred);
  assign block       = is_branch && queueFull && !(pop && !mis);
  assign redirect_pc = resolveTaken ? resolveTarget : head.fallthru;
  assign mispredict  = (state_q == REDIRECT);

  assign push_data.pc       = pc;
  assign push_data.instr    = instr;
  assign push_data.pred     = predictBranch;
  assign push_data.fallthru = pc + 32'd4;

  pred_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rstN      (rstN),
    .push      (push),
    .pop       (pop),
    .flush     (mis),
    .push_data (push_data),
    .head      (head),
    .full      (queueFull),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    push       = 1'b0;
    fetchValid = 1'b0;
    case (state_q)
      RUN: begin
        if (started && !stall && !block) begin
          fetchValid = 1'b1;
          push       = is_branch;
          pc_d       = (is_branch && predictBranch) ? pc + b_offset(instr) : pc + 32'd4;
        end
      end
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
    // a mispredict wins over stall and drops whatever was fetched this cycle
    if (mis) begin
      state_d = REDIRECT;
      pc_d    = redirect_pc;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc          <= RESET_PC;
      started     <= 1'b0;
      trainValid  <= 1'b0;
      prevInstr   <= '0;
      branchTaken <= 1'b0;
    end else begin
      pc         <= pc_d;
      started    <= 1'b1;
      trainValid <= pop;
      if (pop) begin
        prevInstr   <= head.instr;
        branchTaken <= resolveTaken;
      end
    end
  end

  stored_fallthru_consistent: assert property (@(posedge clk) disable iff (!rstN)
    !empty |-> head.fallthru == head.pc + 32'd4);

`ifdef FETCH_STATS_EN
  logic [15:0] branch_cnt;
  logic [15:0] mis_cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      branch_cnt <= '0;
      mis_cnt    <= '0;
    end else begin
      if (push && branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
      if (mis && mis_cnt != 16'hFFFF)     mis_cnt    <= mis_cnt + 16'd1;
    end
  end

  assign branchCount     = branch_cnt;
  assign mispredictCount = mis_cnt;
`else
  assign branchCount     = '0;
  assign mispredictCount = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - self-checking bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BR20 = 32'h0200_0063;
  localparam logic [31:0] BR8  = 32'h0000_0463;
  localparam logic [31:0] BRN8 = 32'hFE00_0CE3;

  logic        clk = 1'b0;
  logic        rstN;
  logic        stall;
  logic [31:0] instr;
  logic        predictBranch;
  logic        resolveValid;
  logic        resolveTaken;
  logic [31:0] resolveTarget;
  logic [31:0] pc;
  logic        fetchValid;
  logic [31:0] currInstr;
  logic [31:0] prevInstr;
  logic        branchTaken;
  logic        trainValid;
  logic        mispredict;
  logic        queueFull;
  logic [15:0] branchCount;
  logic [15:0] mispredictCount;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .clk             (clk),
    .rstN            (rstN),
    .stall           (stall),
    .instr           (instr),
    .predictBranch   (predictBranch),
    .resolveValid    (resolveValid),
    .resolveTaken    (resolveTaken),
    .resolveTarget   (resolveTarget),
    .pc              (pc),
    .fetchValid      (fetchValid),
    .currInstr       (currInstr),
    .prevInstr       (prevInstr),
    .branchTaken     (branchTaken),
    .trainValid      (trainValid),
    .mispredict      (mispredict),
    .queueFull       (queueFull),
    .branchCount     (branchCount),
    .mispredictCount (mispredictCount)
  );

  typedef struct {
    logic [31:0] instr;
    logic        pb;
    logic        st;
    logic        rv;
    logic        rt;
    logic [31:0] rtg;
    logic [31:0] epc;
    logic        efv;
    logic        efull;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        taken;
    logic        mis;
  } train_t;

  typedef struct {
    logic [31:0] instr;
    logic        pred;
  } fl_t;

  vec_t   tbl[$];
  train_t sb[$];
  fl_t    inflight[$];
  int     total = 0;
  int     passed = 0;
  int     exp_pushes = 0;
  int     exp_mis = 0;

  function automatic void add(input logic [31:0] i, input logic pb, st, rv, rt,
                              input logic [31:0] rtg, epc, input logic efv, efull);
    vec_t v;
    v.instr = i; v.pb = pb; v.st = st; v.rv = rv; v.rt = rt;
    v.rtg = rtg; v.epc = epc; v.efv = efv; v.efull = efull;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_train(input string tag);
    train_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_trainValid"}, 32'(trainValid), 32'd1);
      chk({tag, "_prevInstr"}, prevInstr, e.instr);
      chk({tag, "_branchTaken"}, 32'(branchTaken), 32'(e.taken));
      chk({tag, "_mispredict"}, 32'(mispredict), 32'(e.mis));
    end else begin
      chk({tag, "_trainValid_idle"}, 32'(trainValid), 32'd0);
      chk({tag, "_mispredict_idle"}, 32'(mispredict), 32'd0);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    fl_t  h;
    logic m;
    instr = v.instr; predictBranch = v.pb; stall = v.st;
    resolveValid = v.rv; resolveTaken = v.rt; resolveTarget = v.rtg;
    #1;
    chk({tag, "_pc"}, pc, v.epc);
    chk({tag, "_fetchValid"}, 32'(fetchValid), 32'(v.efv));
    chk({tag, "_queueFull"}, 32'(queueFull), 32'(v.efull));
    m = 1'b0;
    if (v.rv && inflight.size() > 0) begin
      h = inflight.pop_front();
      m = (v.rt != h.pred);
      sb.push_back('{h.instr, v.rt, m});
      if (m) begin
        inflight.delete();
        exp_mis++;
      end
    end
    if (v.instr[6:0] == 7'b1100011 && v.efv && !m) begin
      inflight.push_back('{v.instr, v.pb});
      exp_pushes++;
    end
    @(posedge clk); #1;
    check_train(tag);
    resolveValid = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; stall = 1'b0; instr = NOP; predictBranch = 1'b0;
    resolveValid = 1'b0; resolveTaken = 1'b0; resolveTarget = '0;

    //      instr pb st rv rt rtg           epc        efv efull
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h000, 1, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h004, 1, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h008, 1, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h00C, 1, 0);
    add(BR20, 1, 0, 0, 0, 32'h0,        32'h010, 1, 0);
    add(NOP,  0, 0, 1, 1, 32'h0,        32'h030, 1, 0);
    add(BR20, 1, 0, 0, 0, 32'h0,        32'h034, 1, 0);
    add(NOP,  0, 0, 1, 0, 32'h999,      32'h054, 1, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h038, 0, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h038, 1, 0);
    add(NOP,  0, 0, 1, 1, 32'h0,        32'h03C, 1, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h040, 1, 0);
    add(BR8,  0, 0, 0, 0, 32'h0,        32'h044, 1, 0);
    add(BR8,  0, 0, 0, 0, 32'h0,        32'h048, 1, 0);
    add(BR8,  0, 0, 0, 0, 32'h0,        32'h04C, 1, 0);
    add(BR8,  0, 0, 0, 0, 32'h0,        32'h050, 1, 0);
    add(BR8,  0, 0, 0, 0, 32'h0,        32'h054, 0, 1);
    add(BR8,  0, 0, 0, 0, 32'h0,        32'h054, 0, 1);
    add(BR8,  0, 0, 1, 0, 32'h0,        32'h054, 1, 1);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h058, 1, 1);
    add(NOP,  0, 0, 1, 1, 32'h200,      32'h05C, 1, 1);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h200, 0, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h200, 1, 0);
    add(BRN8, 1, 0, 0, 0, 32'h0,        32'h204, 1, 0);
    add(NOP,  0, 0, 1, 1, 32'h0,        32'h1FC, 1, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h200, 1, 0);
    add(BR20, 1, 1, 0, 0, 32'h0,        32'h204, 0, 0);
    add(BR20, 1, 0, 0, 0, 32'h0,        32'h204, 1, 0);
    add(NOP,  0, 1, 1, 0, 32'hDEAD0000, 32'h224, 0, 0);
    add(NOP,  0, 1, 0, 0, 32'h0,        32'h208, 0, 0);
    add(NOP,  0, 0, 0, 0, 32'h0,        32'h208, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fetchValid", 32'(fetchValid), 32'd0);
    chk("rst_trainValid", 32'(trainValid), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_queueFull", 32'(queueFull), 32'd0);
    chk("rst_prevInstr", prevInstr, 32'h0);
    chk("rst_branchTaken", 32'(branchTaken), 32'd0);
    rstN = 1'b1;
    #1;
    chk("prestart_fetchValid", 32'(fetchValid), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

    // fill the queue, then pull reset in the middle of a cycle
    for (int i = 0; i < 4; i++)
      step('{BR8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20C + 32'(i * 4), 1'b1, 1'b0},
           $sformatf("fill%0d", i));
    #1;
    chk("prereset_queueFull", 32'(queueFull), 32'd1);
    chk("prereset_pc", pc, 32'h21C);
    rstN = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_queueFull", 32'(queueFull), 32'd0);
    chk("async_rst_fetchValid", 32'(fetchValid), 32'd0);
    inflight.delete();
    sb.delete();
    exp_pushes = 0;
    exp_mis = 0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;

    step('{NOP,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h00, 1'b1, 1'b0}, "post0");
    step('{NOP,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h04, 1'b1, 1'b0}, "post1");
    step('{NOP,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h08, 1'b1, 1'b0}, "post2");
    step('{NOP,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0C, 1'b1, 1'b0}, "post3");
    step('{BR20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h10, 1'b1, 1'b0}, "post4");
    step('{NOP,  1'b0, 1'b0, 1'b1, 1'b0, 32'h777, 32'h30, 1'b1, 1'b0}, "post5");
    step('{NOP,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h14, 1'b0, 1'b0}, "post6");
    step('{NOP,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h14, 1'b1, 1'b0}, "post7");

`ifdef FETCH_STATS_EN
    chk("branchCount", 32'(branchCount), 32'(exp_pushes));
    chk("mispredictCount", 32'(mispredictCount), 32'(exp_mis));
`else
    chk("branchCount_tied", 32'(branchCount), 32'd0);
    chk("mispredictCount_tied", 32'(mispredictCount), 32'd0);
`endif
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
